// File: rtl/instr_decode_stage.sv
// Decode stage: buffers fetched words in a small FIFO, decodes them, checks a
// per-register scoreboard for RAW/WAW hazards and issues micro-ops to execute.
module instr_decode_stage #(
    parameter int FIFO_DEPTH = 2,
    parameter int PC_WIDTH   = 17,
    parameter int REG_COUNT  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_WIDTH-1:0]  in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_class,
    output logic [7:0]           out_opcode,
    output logic [4:0]           out_dst,
    output logic [4:0]           out_src,
    output logic [15:0]          out_imm,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic                 out_writes,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_reg,
    input  logic                 flush,
    output logic [REG_COUNT-1:0] busy_mask,
    output logic                 hazard_stall
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd7
    } class_e;

    state_e                state_q, state_d;
    logic [31:0]           instrMem_q [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   pcMem_q    [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [REG_COUNT-1:0]  busy_q, busy_d;

    logic                  outValid_q;
    logic [2:0]            outClass_q;
    logic [7:0]            outOpcode_q;
    logic [4:0]            outDst_q;
    logic [4:0]            outSrc_q;
    logic [15:0]           outImm_q;
    logic [PC_WIDTH-1:0]   outPc_q;
    logic                  outWrites_q;

    logic [31:0]           headInstr;
    logic [PC_WIDTH-1:0]   headPc;
    logic [7:0]            headOpcode;
    logic [4:0]            headDst;
    logic [4:0]            headSrc;
    logic [15:0]           headImm;
    logic                  headValid;
    class_e                decClass;
    logic                  decWrites;
    logic                  decReadsSrc;
    logic                  decReadsDst;
    logic                  blocked;
    logic                  outFree;
    logic                  issue;
    logic                  isRedirect;
    logic                  pushEn;
    logic                  unusedHeadBits;

    assign headInstr  = instrMem_q[rdPtr_q];
    assign headPc     = pcMem_q[rdPtr_q];
    assign headOpcode = headInstr[7:0];
    assign headDst    = headInstr[12:8];
    assign headSrc    = headInstr[20:16];
    assign headImm    = headInstr[31:16];
    assign unusedHeadBits = ^headInstr[15:13];

    assign headValid = (count_q != '0);
    assign in_ready  = (count_q < CNT_W'(FIFO_DEPTH));

    always_comb begin
        decClass    = CLS_ILLEGAL;
        decWrites   = 1'b0;
        decReadsSrc = 1'b0;
        decReadsDst = 1'b0;
        case (headOpcode)
            8'h00: decClass = CLS_NOP;
            8'h01: begin
                decClass  = CLS_ALU;
                decWrites = 1'b1;
            end
            8'h02, 8'h03: begin
                decClass    = CLS_ALU;
                decWrites   = 1'b1;
                decReadsSrc = 1'b1;
                decReadsDst = 1'b1;
            end
            8'h04: begin
                decClass  = CLS_LOAD;
                decWrites = 1'b1;
            end
            8'h05: begin
                decClass    = CLS_STORE;
                decReadsSrc = 1'b1;
            end
            8'h10: decClass = CLS_JUMP;
            default: decClass = CLS_ILLEGAL;
        endcase
    end

    // Hazards look only at the registered scoreboard; a writeback in the same
    // cycle unblocks the head one cycle later.
    assign blocked = (decReadsSrc && busy_q[headSrc]) ||
                     ((decReadsDst || decWrites) && busy_q[headDst]);

    assign hazard_stall = headValid && (state_q == ST_RUN) && blocked;
    assign outFree      = !outValid_q || out_ready;
    assign issue        = headValid && (state_q == ST_RUN) && !blocked && outFree && !flush;
    assign isRedirect   = (decClass == CLS_JUMP) || (decClass == CLS_ILLEGAL);

    // Words arriving after a redirect is issued, while draining, or during a
    // flush are accepted on the handshake but dropped.
    assign pushEn = in_valid && in_ready && (state_q == ST_RUN) && !flush &&
                    !(issue && isRedirect);

    always_comb begin
        state_d = state_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            state_d = ST_RUN;
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else if (state_q == ST_DRAIN) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else if (issue && isRedirect) begin
            state_d = ST_DRAIN;
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (issue) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(pushEn) - CNT_W'(issue);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            instrMem_q[wrPtr_q] <= in_instr;
            pcMem_q[wrPtr_q]    <= in_pc;
        end
    end

    // A set from an issuing writer overrides a same-cycle writeback clear.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_reg] = 1'b0;
        end
        if (issue && decWrites) begin
            busy_d[headDst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outClass_q  <= 3'd0;
            outOpcode_q <= 8'd0;
            outDst_q    <= 5'd0;
            outSrc_q    <= 5'd0;
            outImm_q    <= 16'd0;
            outPc_q     <= '0;
            outWrites_q <= 1'b0;
        end else if (flush) begin
            outValid_q <= 1'b0;
        end else if (issue) begin
            outValid_q  <= 1'b1;
            outClass_q  <= decClass;
            outOpcode_q <= headOpcode;
            outDst_q    <= headDst;
            outSrc_q    <= headSrc;
            outImm_q    <= headImm;
            outPc_q     <= headPc;
            outWrites_q <= decWrites;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_valid  = outValid_q;
    assign out_class  = outClass_q;
    assign out_opcode = outOpcode_q;
    assign out_dst    = outDst_q;
    assign out_src    = outSrc_q;
    assign out_imm    = outImm_q;
    assign out_pc     = outPc_q;
    assign out_writes = outWrites_q;
    assign busy_mask  = busy_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: a decode vector table followed by
// hand-written hazard, backpressure, redirect and flush/reset sequences.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [16:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_class;
    logic [7:0]  out_opcode;
    logic [4:0]  out_dst;
    logic [4:0]  out_src;
    logic [15:0] out_imm;
    logic [16:0] out_pc;
    logic        out_writes;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        flush;
    logic [31:0] busy_mask;
    logic        hazard_stall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [16:0] pc;
        logic [2:0]  cls;
        logic [4:0]  dst;
        logic [4:0]  src;
        logic [15:0] imm;
        logic        wr;
        logic [31:0] busy;
    } vec_t;

    vec_t vecs[10];

    instr_decode_stage #(
        .FIFO_DEPTH(2),
        .PC_WIDTH(17),
        .REG_COUNT(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .in_pc(in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_opcode(out_opcode),
        .out_dst(out_dst),
        .out_src(out_src),
        .out_imm(out_imm),
        .out_pc(out_pc),
        .out_writes(out_writes),
        .wb_valid(wb_valid),
        .wb_reg(wb_reg),
        .flush(flush),
        .busy_mask(busy_mask),
        .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    // Every comparison funnels through here so the counters stay in one place.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [16:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        flush    = 1'b0;
        wb_valid = 1'b0;
        wb_reg   = 5'd0;
        applyStimulus(1'b0, 32'h0, 17'h0);
        tick();
        rst = 1'b0;
    endtask

    // Safety net in case a sequence ever gets stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h00000000, 17'h00010, 3'd0, 5'd0,  5'd0,  16'h0000, 1'b0, 32'h00000000};
        vecs[1] = '{32'hABCD0701, 17'h00020, 3'd1, 5'd7,  5'd13, 16'hABCD, 1'b1, 32'h00000080};
        vecs[2] = '{32'h00031F02, 17'h1FFFC, 3'd1, 5'd31, 5'd3,  16'h0003, 1'b1, 32'h80000000};
        vecs[3] = '{32'h00140A03, 17'h00030, 3'd1, 5'd10, 5'd20, 16'h0014, 1'b1, 32'h00000400};
        vecs[4] = '{32'h12340204, 17'h00034, 3'd2, 5'd2,  5'd20, 16'h1234, 1'b1, 32'h00000004};
        vecs[5] = '{32'h00090005, 17'h00038, 3'd3, 5'd0,  5'd9,  16'h0009, 1'b0, 32'h00000000};
        vecs[6] = '{32'h56780010, 17'h0003C, 3'd4, 5'd0,  5'd24, 16'h5678, 1'b0, 32'h00000000};
        vecs[7] = '{32'h0000057F, 17'h00040, 3'd7, 5'd5,  5'd0,  16'h0000, 1'b0, 32'h00000000};
        vecs[8] = '{32'h000000FF, 17'h00044, 3'd7, 5'd0,  5'd0,  16'h0000, 1'b0, 32'h00000000};
        vecs[9] = '{32'h00000006, 17'h00048, 3'd7, 5'd0,  5'd0,  16'h0000, 1'b0, 32'h00000000};

        out_ready = 1'b0;
        doReset();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_busy", busy_mask, 32'd0);
        checkOutput("rst_hazard", {31'd0, hazard_stall}, 32'd0);
        checkOutput("rst_class", {29'd0, out_class}, 32'd0);
        checkOutput("rst_pc", {15'd0, out_pc}, 32'd0);

        // Decode table: one word per fresh reset, issued one cycle after acceptance.
        for (int i = 0; i < 10; i++) begin
            doReset();
            out_ready = 1'b1;
            applyStimulus(1'b1, vecs[i].instr, vecs[i].pc);
            tick();
            applyStimulus(1'b0, 32'h0, 17'h0);
            checkOutput($sformatf("vec%0d_early", i), {31'd0, out_valid}, 32'd0);
            tick();
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("vec%0d_class", i), {29'd0, out_class}, {29'd0, vecs[i].cls});
            checkOutput($sformatf("vec%0d_opcode", i), {24'd0, out_opcode}, {24'd0, vecs[i].instr[7:0]});
            checkOutput($sformatf("vec%0d_dst", i), {27'd0, out_dst}, {27'd0, vecs[i].dst});
            checkOutput($sformatf("vec%0d_src", i), {27'd0, out_src}, {27'd0, vecs[i].src});
            checkOutput($sformatf("vec%0d_imm", i), {16'd0, out_imm}, {16'd0, vecs[i].imm});
            checkOutput($sformatf("vec%0d_pc", i), {15'd0, out_pc}, {15'd0, vecs[i].pc});
            checkOutput($sformatf("vec%0d_writes", i), {31'd0, out_writes}, {31'd0, vecs[i].wr});
            checkOutput($sformatf("vec%0d_busy", i), busy_mask, vecs[i].busy);
        end

        // LOADI r5 then ADD r5,r3: ADD waits for the writeback of r5.
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h00000501, 17'h00040);
        tick();
        applyStimulus(1'b1, 32'h00030502, 17'h00044);
        tick();
        applyStimulus(1'b0, 32'h0, 17'h0);
        checkOutput("raw_first_pc", {15'd0, out_pc}, 32'h40);
        checkOutput("raw_busy_set", busy_mask, 32'h20);
        checkOutput("raw_stall", {31'd0, hazard_stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("raw_held%0d", i), {31'd0, out_valid}, 32'd0);
            checkOutput($sformatf("raw_stall%0d", i), {31'd0, hazard_stall}, 32'd1);
        end
        wb_valid = 1'b1;
        wb_reg   = 5'd5;
        tick();
        wb_valid = 1'b0;
        checkOutput("raw_wb_busy", busy_mask, 32'd0);
        checkOutput("raw_wb_notyet", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("raw_issue_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("raw_issue_opcode", {24'd0, out_opcode}, 32'h02);
        checkOutput("raw_issue_pc", {15'd0, out_pc}, 32'h44);
        checkOutput("raw_issue_src", {27'd0, out_src}, 32'd3);
        checkOutput("raw_reset_busy", busy_mask, 32'h20);

        // Writeback of a register that is being set in the same cycle: set wins.
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h00000501, 17'h00050);
        tick();
        applyStimulus(1'b0, 32'h0, 17'h0);
        wb_valid = 1'b1;
        wb_reg   = 5'd5;
        tick();
        wb_valid = 1'b0;
        checkOutput("setwins_busy", busy_mask, 32'h20);

        // Backpressure: three LOADIs with execute stalled.
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h00000101, 17'h00100);
        tick();
        applyStimulus(1'b1, 32'h00000201, 17'h00104);
        tick();
        applyStimulus(1'b1, 32'h00000301, 17'h00108);
        tick();
        applyStimulus(1'b0, 32'h0, 17'h0);
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("bp_hold_pc%0d", i), {15'd0, out_pc}, 32'h100);
            checkOutput($sformatf("bp_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
        end
        checkOutput("bp_hold_dst", {27'd0, out_dst}, 32'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_drain1", {15'd0, out_pc}, 32'h104);
        tick();
        checkOutput("bp_drain2", {15'd0, out_pc}, 32'h108);
        tick();
        checkOutput("bp_drain_done", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_busy", busy_mask, 32'h0000000E);

        // Jump: following words are dropped until flush.
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h12340010, 17'h00200);
        tick();
        applyStimulus(1'b1, 32'h00030502, 17'h00204);
        tick();
        checkOutput("jmp_class", {29'd0, out_class}, 32'd4);
        checkOutput("jmp_imm", {16'd0, out_imm}, 32'h1234);
        applyStimulus(1'b1, 32'h00030502, 17'h00208);
        tick();
        applyStimulus(1'b0, 32'h0, 17'h0);
        checkOutput("jmp_no_issue", {31'd0, out_valid}, 32'd0);
        checkOutput("jmp_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("jmp_still_idle", {31'd0, out_valid}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b1, 32'h00000000, 17'h00300);
        tick();
        applyStimulus(1'b0, 32'h0, 17'h0);
        tick();
        checkOutput("jmp_after_flush_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("jmp_after_flush_pc", {15'd0, out_pc}, 32'h300);
        checkOutput("jmp_after_flush_class", {29'd0, out_class}, 32'd0);

        // Illegal opcode after a writer: scoreboard untouched, then draining.
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h00000501, 17'h00070);
        tick();
        applyStimulus(1'b1, 32'h0000057F, 17'h00080);
        tick();
        applyStimulus(1'b0, 32'h0, 17'h0);
        tick();
        checkOutput("ill_class", {29'd0, out_class}, 32'd7);
        checkOutput("ill_writes", {31'd0, out_writes}, 32'd0);
        checkOutput("ill_busy", busy_mask, 32'h20);
        applyStimulus(1'b1, 32'h00000000, 17'h00084);
        tick();
        applyStimulus(1'b0, 32'h0, 17'h0);
        tick();
        checkOutput("ill_drain_idle", {31'd0, out_valid}, 32'd0);
        checkOutput("ill_drain_ready", {31'd0, in_ready}, 32'd1);

        // Flush and reset with two buffered ops, a held output and a wb of r5.
        for (int mode = 0; mode < 2; mode++) begin
            doReset();
            out_ready = 1'b1;
            applyStimulus(1'b1, 32'h00000501, 17'h00400);
            tick();
            out_ready = 1'b0;
            applyStimulus(1'b1, 32'h00000000, 17'h00404);
            tick();
            applyStimulus(1'b1, 32'h00000000, 17'h00408);
            tick();
            checkOutput($sformatf("fl%0d_pre_ready", mode), {31'd0, in_ready}, 32'd0);
            checkOutput($sformatf("fl%0d_pre_busy", mode), busy_mask, 32'h20);
            applyStimulus(1'b1, 32'h00000000, 17'h0040C);
            wb_valid = 1'b1;
            wb_reg   = 5'd5;
            if (mode == 0) flush = 1'b1;
            else rst = 1'b1;
            tick();
            flush    = 1'b0;
            rst      = 1'b0;
            wb_valid = 1'b0;
            applyStimulus(1'b0, 32'h0, 17'h0);
            checkOutput($sformatf("fl%0d_valid", mode), {31'd0, out_valid}, 32'd0);
            checkOutput($sformatf("fl%0d_busy", mode), busy_mask, 32'd0);
            checkOutput($sformatf("fl%0d_in_ready", mode), {31'd0, in_ready}, 32'd1);
            checkOutput($sformatf("fl%0d_hazard", mode), {31'd0, hazard_stall}, 32'd0);
            out_ready = 1'b1;
            tick();
            checkOutput($sformatf("fl%0d_empty", mode), {31'd0, out_valid}, 32'd0);
        end
        checkOutput("rst_mid_pc", {15'd0, out_pc}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Stage directly downstream of the instruction fetcher.
- Accepts 4-byte instruction words tagged with their PC and buffers them in a small FIFO.
- Decodes opcode and register/immediate fields, then checks a per-register scoreboard for RAW and WAW hazards.
- Issues decoded micro-ops to execute over a valid/ready handshake; jump/illegal ops block further issue until execute flushes.

Parameters:
FIFO_DEPTH, 2, input buffer entries (power of two, >=2)
PC_WIDTH, 17, width of instruction address tag
REG_COUNT, 32, architectural registers per process (index width 5)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  reset: synchronous, active-high
in_valid  in  1  fetcher presents a word
in_ready  out  1  decoder accepts word this cycle
in_instr  in  32  byte0=[7:0] opcode, byte1=[15:8], byte2=[23:16], byte3=[31:24]
in_pc  in  PC_WIDTH  address of byte0
out_valid  out  1  decoded op available
out_ready  in  1  execute consumes op
out_class  out  3  0 NOP, 1 ALU, 2 LOAD, 3 STORE, 4 JUMP, 7 ILLEGAL
out_opcode  out  8  raw opcode
out_dst  out  5  byte1[4:0]
out_src  out  5  byte2[4:0]
out_imm  out  16  {byte3,byte2}
out_pc  out  PC_WIDTH  tag of issued op
out_writes  out  1  op writes out_dst
wb_valid  in  1  execute retired a register write
wb_reg  in  5  register written
flush  in  1  redirect: discard all buffered/pending ops
busy_mask  out  REG_COUNT  scoreboard (debug/verification)
hazard_stall  out  1  head op blocked by scoreboard

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, state RUN, out_valid=0, all out_* fields=0, busy_mask=0, hazard_stall=0, in_ready=1 on the following cycle.
- Opcode map:
  - 0x00 NOP (class 0, no regs).
  - 0x01 LOADI dst<-imm (ALU, writes, no src).
  - 0x02 ADD dst,src and 0x03 SUB dst,src (ALU, writes, reads src and dst).
  - 0x04 LOAD dst<-[imm] (LOAD, writes).
  - 0x05 STORE [imm]<-src (STORE, reads src).
  - 0x10 JMP imm (JUMP).
  - Any other opcode is ILLEGAL.
- FIFO handshake:
  - in_ready = (count < FIFO_DEPTH), derived from registered count only.
  - No push when full, even if a pop occurs in the same cycle.
  - Push on in_valid&&in_ready. Pointers wrap modulo FIFO_DEPTH.
- Hazard check on the FIFO head, using the registered busy_mask only (a same-cycle wb is not bypassed):
  - stall if an op that reads src has busy_mask[src]=1;
  - stall if an op that reads or writes dst has busy_mask[dst]=1.
  - hazard_stall=1 when the head is valid, state is RUN, and the head is blocked.
- Issue condition: FIFO non-empty, state RUN, no hazard, and (out_valid=0 or out_ready=1).
- On issue:
  - load the output register and pop the FIFO;
  - if out_writes, set busy_mask[dst] next cycle.
- Latency: a word accepted at cycle N can appear at out_valid at N+1 at the earliest.
- Output hold: out_* stay stable while out_valid&&!out_ready. out_valid drops after a consume with no new issue.
- Scoreboard:
  - wb_valid clears busy_mask[wb_reg].
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - wb of a non-busy register is ignored.
- States:
  - RUN -> DRAIN when a JUMP or ILLEGAL op is issued.
  - In DRAIN: no issue, in_ready=1, incoming words are discarded, and the FIFO is emptied.
  - DRAIN -> RUN only on flush.
- flush (highest priority after rst):
  - next cycle FIFO is empty, out_valid=0, state RUN;
  - any word presented that cycle is discarded;
  - busy_mask is kept, because in-flight writes still retire (wb in the same cycle still applies).
- rst mid-transfer: all state returns to reset values; a wb in the same cycle is ignored.

Test Plan:
- Reset, then push 0x00000501 (LOADI r5,0x0000), pc 0x40, out_ready=1 -> out_valid at next cycle, class 1, dst 5, out_writes 1, pc 0x40; busy_mask=0x20 one cycle later.
- Back-to-back LOADI r5 then ADD r5,r3 (0x00030502), no wb -> ADD held, hazard_stall=1. wb_valid,wb_reg=5 -> ADD issues exactly 2 cycles after the wb cycle; busy_mask[5] set again.
- out_ready=0 with 3 words pushed -> in_ready=0 once FIFO holds 2 and output is full; out_* unchanged across 10 cycles; raising out_ready drains all in order.
- JMP 0x1234 (0x12340010) followed by 2 ADDs -> JUMP issued with imm 0x1234, then no issue and in_ready=1 (ADDs dropped); flush -> RUN, next pushed NOP issues.
- Opcode 0x7F -> class 7 ILLEGAL, state DRAIN, busy_mask unchanged.
- Assert flush while the FIFO holds 2 ops and out_valid=1, with wb_valid for r5 in the same cycle -> next cycle out_valid=0, FIFO empty, busy_mask[5]=0. Repeat with rst instead -> busy_mask=0.
